// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core with private instruction memory, register file and data memory.
// Storage lives in the named scopes DUT_instr, DUT_RF and DUT_Data so benches can reach it hierarchically.
module rv32i_single_cycle_core #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic n_rst
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] alu_b, alu_res;
  logic        alu_alt;
  logic        br_taken;
  logic [31:0] dmem_addr, dmem_rdata;
  logic        dmem_we;
  logic        rf_we;
  logic [31:0] rd_wdata;
  logic [31:0] pc_plus4;
  logic        unused_addr_bits;

  if (1'b1) begin : DUT_instr
    logic [31:0] instruction_memory [0:IMEM_DEPTH-1];
    assign instr = instruction_memory[pc_q[IAW+1:2]];
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  if (1'b1) begin : DUT_RF
    logic [31:0] RF [0:31];
    always_ff @(posedge clk) begin
      if (n_rst) begin
        for (int i = 0; i < 32; i++) RF[i] <= '0;
      end else if (rf_we && (rd != 5'd0)) begin
        RF[rd] <= rd_wdata;
      end
    end
    assign rs1_val = (rs1 == 5'd0) ? '0 : RF[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : RF[rs2];
  end

  // bit 30 selects sub/sra only for register ops and for the shift-right immediate form
  assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
  assign alu_alt = instr[30] & ((opcode == OP_REG) | (funct3 == 3'b101));

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'b0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0]) : (rs1_val >> alu_b[4:0]);
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign dmem_addr        = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign unused_addr_bits = ^{dmem_addr[31:DAW+2], dmem_addr[1:0]};

  if (1'b1) begin : DUT_Data
    logic [31:0] data_memory [0:DMEM_DEPTH-1];
    always_ff @(posedge clk) begin
      if (!n_rst && dmem_we) data_memory[dmem_addr[DAW+1:2]] <= rs2_val;
    end
    assign dmem_rdata = data_memory[dmem_addr[DAW+1:2]];
  end

  assign pc_plus4 = pc_q + 32'd4;

  // unrecognised opcodes (and non-word load/store widths) fall through as NOPs
  always_comb begin
    rf_we    = 1'b0;
    dmem_we  = 1'b0;
    rd_wdata = alu_res;
    pc_d     = pc_plus4;
    case (opcode)
      OP_REG, OP_IMM: rf_we = 1'b1;
      OP_LUI: begin
        rf_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rf_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      OP_JAL: begin
        rf_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OP_JALR: begin
        rf_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we    = 1'b1;
          rd_wdata = dmem_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) dmem_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed programs for the single-cycle core; expected architectural state is queued
// as each program is set up and compared once the core has run.
module tb_rv32i_single_cycle_core;
  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  rv32i_single_cycle_core #(
    .IMEM_DEPTH(256),
    .DMEM_DEPTH(256),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .n_rst(n_rst)
  );

  localparam int K_RF = 0;
  localparam int K_DM = 1;
  localparam int K_PC = 2;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_RF:    return dut.DUT_RF.RF[idx];
      K_DM:    return dut.DUT_Data.data_memory[idx];
      default: return dut.pc_q;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.idx);
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int f3, input int rd,
                                        input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input int rd, input logic [6:0] op);
    return {imm, 5'(rd), op};
  endfunction

  task automatic p(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) begin
      if (i < prog.size()) dut.DUT_instr.instruction_memory[i] = prog[i];
      else                 dut.DUT_instr.instruction_memory[i] = 32'h0;
    end
    prog.delete();
  endtask

  task automatic hold_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    n_rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // arithmetic, reset state and first-edge latency
    hold_reset();
    p(addi(1, 0, 10)); p(addi(2, 0, 5)); p(enc_r(7'h00, 0, 3, 1, 2)); p(enc_r(7'h20, 0, 4, 1, 2));
    load_prog();
    dut.DUT_RF.RF[7] = 32'hdeadbeef;
    @(posedge clk);
    #1;
    expect_val("rst_x7", K_RF, 7, 32'h0);
    expect_val("rst_pc", K_PC, 0, 32'h0);
    drain();
    @(negedge clk);
    n_rst = 1'b0;
    run(1);
    expect_val("lat_x1", K_RF, 1, 32'd10);
    expect_val("lat_x2", K_RF, 2, 32'd0);
    expect_val("lat_pc", K_PC, 0, 32'd4);
    drain();
    run(6);
    expect_val("arith_x1", K_RF, 1, 32'd10);
    expect_val("arith_x2", K_RF, 2, 32'd5);
    expect_val("arith_x3", K_RF, 3, 32'd15);
    expect_val("arith_x4", K_RF, 4, 32'd5);
    drain();

    // store then load back, load result used immediately
    hold_reset();
    p(addi(1, 0, 100)); p(sw(1, 0, 0)); p({12'd0, 5'd0, 3'b010, 5'd2, 7'h03}); p(addi(3, 2, 1));
    load_prog();
    dut.DUT_Data.data_memory[0] = 32'h0;
    release_reset();
    run(4);
    expect_val("mem_dm0", K_DM, 0, 32'd100);
    expect_val("mem_x2", K_RF, 2, 32'd100);
    expect_val("mem_x3", K_RF, 3, 32'd101);
    drain();

    // bne loop counting to 5, then NOP fall-through
    hold_reset();
    p(addi(1, 0, 0)); p(addi(2, 0, 5)); p(addi(1, 1, 1)); p(br(1, 1, 2, -4));
    load_prog();
    release_reset();
    run(12);
    expect_val("loop_x1", K_RF, 1, 32'd5);
    expect_val("loop_pc12", K_PC, 0, 32'd16);
    drain();
    run(8);
    expect_val("loop_x1_end", K_RF, 1, 32'd5);
    expect_val("loop_pc20", K_PC, 0, 32'd48);
    drain();

    // back-to-back accumulate on the same registers
    hold_reset();
    p(addi(1, 1, 1)); p(addi(2, 2, 1)); p(addi(1, 1, 1)); p(addi(2, 2, 1));
    p(addi(1, 1, 1)); p(addi(2, 2, 1)); p(addi(1, 1, 1)); p(addi(1, 1, 1));
    load_prog();
    release_reset();
    run(8);
    expect_val("acc_x1", K_RF, 1, 32'd5);
    expect_val("acc_x2", K_RF, 2, 32'd3);
    drain();

    // shifts, compares, upper immediates, jalr, signed/unsigned branches, x0
    hold_reset();
    p(enc_u(20'h80000, 1, 7'h37));
    p(enc_i(32'h404, 1, 5, 2, 7'h13));
    p(enc_i(4, 1, 5, 3, 7'h13));
    p(enc_r(7'h00, 2, 4, 1, 0));
    p(enc_r(7'h00, 3, 5, 1, 0));
    p(enc_u(20'h00001, 6, 7'h17));
    p(enc_i(40, 0, 0, 7, 7'h67));
    p(addi(8, 0, 1));
    p(32'h0); p(32'h0);
    p(enc_i(-1, 1, 4, 9, 7'h13));
    p(br(4, 1, 0, 8));
    p(addi(8, 0, 2));
    p(br(7, 1, 0, 8));
    p(addi(8, 0, 3));
    p(addi(10, 0, -3));
    p(enc_r(7'h00, 7, 11, 10, 9));
    p(addi(0, 0, 7));
    load_prog();
    release_reset();
    run(20);
    expect_val("lui_x1", K_RF, 1, 32'h8000_0000);
    expect_val("srai_x2", K_RF, 2, 32'hF800_0000);
    expect_val("srli_x3", K_RF, 3, 32'h0800_0000);
    expect_val("slt_x4", K_RF, 4, 32'd1);
    expect_val("sltu_x5", K_RF, 5, 32'd0);
    expect_val("auipc_x6", K_RF, 6, 32'h0000_1014);
    expect_val("jalr_x7", K_RF, 7, 32'd28);
    expect_val("skip_x8", K_RF, 8, 32'd0);
    expect_val("xori_x9", K_RF, 9, 32'h7FFF_FFFF);
    expect_val("neg_x10", K_RF, 10, 32'hFFFF_FFFD);
    expect_val("and_x11", K_RF, 11, 32'h7FFF_FFFD);
    expect_val("x0_zero", K_RF, 0, 32'h0);
    expect_val("misc_pc", K_PC, 0, 32'd100);
    drain();

    // iterative Fibonacci with n poked into x5 while held in reset
    hold_reset();
    p(addi(10, 0, 0)); p(addi(11, 0, 1)); p(br(0, 5, 0, 24)); p(enc_r(7'h00, 0, 12, 10, 11));
    p(addi(10, 11, 0)); p(addi(11, 12, 0)); p(addi(5, 5, -1)); p(jal(0, -20)); p(jal(0, 0));
    load_prog();
    @(posedge clk);
    #1;
    dut.DUT_RF.RF[5] = 32'd10;
    @(negedge clk);
    n_rst = 1'b0;
    run(100);
    expect_val("fib_x10", K_RF, 10, 32'd55);
    expect_val("fib_x11", K_RF, 11, 32'd89);
    expect_val("fib_x5", K_RF, 5, 32'd0);
    expect_val("fib_pc", K_PC, 0, 32'd32);
    drain();

    // reset asserted mid-loop: PC and RF cleared, data memory kept
    hold_reset();
    p(addi(1, 0, 0)); p(addi(2, 0, 50)); p(addi(1, 1, 1)); p(br(1, 1, 2, -4));
    load_prog();
    dut.DUT_Data.data_memory[3] = 32'h0000_1234;
    release_reset();
    run(10);
    expect_val("mid_x1", K_RF, 1, 32'd4);
    expect_val("mid_pc", K_PC, 0, 32'd8);
    drain();
    hold_reset();
    @(posedge clk);
    #1;
    expect_val("rst2_pc", K_PC, 0, 32'h0);
    expect_val("rst2_x1", K_RF, 1, 32'h0);
    expect_val("rst2_x2", K_RF, 2, 32'h0);
    expect_val("rst2_dm3", K_DM, 3, 32'h0000_1234);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
